park_keypad: RTL

PARK_KEYPAD -- requirements
Module: park_keypad

---
 rtl/park_pkg.sv | 23 ++
 rtl/park_timer.sv | 35 +++
 rtl/park_keypad.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/park_pkg.sv
// Shared types and default constants for the parking-gate keypad.
package park_pkg;

    // Controller states; every state is held in a register.
    typedef enum logic [2:0] {
        StIdle,
        StKey1,
        StKey2,
        StWaitResp,
        StGranted,
        StLockout
    } park_state_e;

    localparam int unsigned KeyTimeoutDef  = 64;
    localparam int unsigned RespTimeoutDef = 32;
    localparam int unsigned MaxTriesDef    = 3;
    localparam int unsigned LockCyclesDef  = 128;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/park_timer.sv
// Loadable down-counter; expires when the count reaches zero and never wraps.
module park_timer #(
    parameter int unsigned Width = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load_i,
    input  logic [Width-1:0] load_val_i,
    output logic             expired_o
);

    logic [Width-1:0] cnt_q, cnt_d;

    // Load has priority; otherwise count down and stick at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/park_keypad.sv
// Two-digit keypad entry controller for a parking gate with retry lockout.
module park_keypad
    import park_pkg::*;
#(
    parameter int unsigned KEY_TIMEOUT  = KeyTimeoutDef,
    parameter int unsigned RESP_TIMEOUT = RespTimeoutDef,
    parameter int unsigned MAX_TRIES    = MaxTriesDef,
    parameter int unsigned LOCK_CYCLES  = LockCyclesDef
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       car_arrive,
    input  logic       key_valid,
    input  logic [1:0] key_val,
    input  logic       green_led,
    input  logic       red_led,
    output logic       enter,
    output logic [1:0] code1,
    output logic [1:0] code2,
    output logic       granted,
    output logic       locked,
    output logic [1:0] tries
);

    localparam int unsigned MaxTimeout =
        max_u(max_u(KEY_TIMEOUT, RESP_TIMEOUT), LOCK_CYCLES);
    localparam int unsigned TimerW = $clog2(MaxTimeout) + 1;

    // Timer is loaded with N-1 on entry so the state lasts exactly N cycles.
    localparam logic [TimerW-1:0] KeyLoad  = TimerW'(KEY_TIMEOUT - 1);
    localparam logic [TimerW-1:0] RespLoad = TimerW'(RESP_TIMEOUT - 1);
    localparam logic [TimerW-1:0] LockLoad = TimerW'(LOCK_CYCLES - 1);
    localparam logic [2:0]        MaxTriesW = 3'(MAX_TRIES);

    park_state_e       state_q, state_d;
    logic [1:0]        code1_q, code1_d;
    logic [1:0]        code2_q, code2_d;
    logic [1:0]        tries_q, tries_d;
    logic              granted_q, granted_d;
    logic              reject;
    logic [2:0]        tries_inc;
    logic              tmr_load;
    logic [TimerW-1:0] tmr_load_val;
    logic              tmr_expired;

    park_timer #(
        .Width (TimerW)
    ) u_timer (
        .clock      (clock),
        .reset      (reset),
        .load_i     (tmr_load),
        .load_val_i (tmr_load_val),
        .expired_o  (tmr_expired)
    );

    assign tries_inc = {1'b0, tries_q} + 3'd1;

    // Next-state, capture, try counting and timer reload on every state change.
    always_comb begin
        state_d      = state_q;
        code1_d      = code1_q;
        code2_d      = code2_q;
        tries_d      = tries_q;
        granted_d    = 1'b0;
        reject       = 1'b0;
        tmr_load     = 1'b0;
        tmr_load_val = '0;

        unique case (state_q)
            StIdle: begin
                if (car_arrive) state_d = StKey1;
            end
            StKey1: begin
                if (!car_arrive) begin
                    state_d = StIdle;
                    tries_d = '0;
                end else if (key_valid) begin
                    code1_d = key_val;
                    state_d = StKey2;
                end else if (tmr_expired) begin
                    state_d = StIdle;
                end
            end
            StKey2: begin
                if (!car_arrive) begin
                    state_d = StIdle;
                    tries_d = '0;
                end else if (key_valid) begin
                    code2_d = key_val;
                    state_d = StWaitResp;
                end else if (tmr_expired) begin
                    state_d = StIdle;
                end
            end
            StWaitResp: begin
                // Red wins over green when both arrive together.
                if (!car_arrive) begin
                    state_d = StIdle;
                    tries_d = '0;
                end else if (red_led) begin
                    reject = 1'b1;
                end else if (green_led) begin
                    state_d   = StGranted;
                    granted_d = 1'b1;
                end else if (tmr_expired) begin
                    reject = 1'b1;
                end
            end
            StGranted: begin
                if (!car_arrive) begin
                    state_d = StIdle;
                    tries_d = '0;
                end
            end
            StLockout: begin
                if (tmr_expired) begin
                    state_d = StIdle;
                    tries_d = '0;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (reject) begin
            if (tries_inc <= MaxTriesW) tries_d = tries_inc[1:0];
            state_d = (tries_inc == MaxTriesW) ? StLockout : StKey1;
        end

        tmr_load = (state_d != state_q);
        unique case (state_d)
            StKey1, StKey2: tmr_load_val = KeyLoad;
            StWaitResp:     tmr_load_val = RespLoad;
            StLockout:      tmr_load_val = LockLoad;
            default:        tmr_load_val = '0;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            code1_q   <= '0;
            code2_q   <= '0;
            tries_q   <= '0;
            granted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            code1_q   <= code1_d;
            code2_q   <= code2_d;
            tries_q   <= tries_d;
            granted_q <= granted_d;
        end
    end

    // Decoded from the state register so reset clears them without a clock edge.
    assign enter   = (state_q == StWaitResp);
    assign locked  = (state_q == StLockout);
    assign granted = granted_q;
    assign code1   = code1_q;
    assign code2   = code2_q;
    assign tries   = tries_q;

endmodule
